fifo_n_pipe: RTL and testbench
==============================

// Module: fifo_n_pipe
// PURPOSE
//  Parametrised N-entry successor to the single-entry enq/deq FIFO. Buffers WIDTH-bit
//  messages between an atomic-method producer (in$enq) and consumer (out$deq/out$first).
//  Adds configurable depth, an occupancy count, and an optional pipelined mode that
//  accepts enq while full if deq fires in the same cycle. Used between echo request/indication stages.
// PARAMETERS
//  WIDTH      704  message width in bits (>=1)
//  DEPTH      4    number of entries (>=2; need not be a power of two)
//  PIPELINED  0    1: in$enq__RDY also asserted when full and out$deq__ENA=1 this cycle
// PORTS
//  CLK             in   1              clock, all state updates on rising edge
//  nRST            in   1              reset, asynchronous assert, active-low
//  in$enq__ENA     in   1              enqueue strobe; ignored unless in$enq__RDY
//  in$enq$v        in   WIDTH          enqueue data
//  in$enq__RDY     out  1              enqueue permitted this cycle
//  out$deq__ENA    in   1              dequeue strobe; ignored unless out$deq__RDY
//  out$deq__RDY    out  1              dequeue permitted (count != 0)
//  out$first       out  WIDTH          head entry; valid only while out$first__RDY
//  out$first__RDY  out  1              head valid (== out$deq__RDY)
//  count           out  $clog2(DEPTH+1) current occupancy 0..DEPTH
// BEHAVIOUR
//  - State: storage[DEPTH], rd_ptr, wr_ptr ($clog2(DEPTH) bits, min 1), count register.
//  - Reset (nRST=0, async, any time incl. mid-transfer): rd_ptr=wr_ptr=count=0 immediately;
//    in$enq__RDY=1, out$deq__RDY=out$first__RDY=0, count=0. Storage is not reset.
//  - enq_fire = in$enq__ENA & in$enq__RDY; deq_fire = out$deq__ENA & out$deq__RDY.
//  - in$enq__RDY = (count != DEPTH) | (PIPELINED & out$deq__ENA & (count != 0)).
//  - enq_fire: storage[wr_ptr] <= in$enq$v; wr_ptr advances. deq_fire: rd_ptr advances.
//  - Pointer wrap: ptr == DEPTH-1 -> 0, else ptr+1 (explicit compare, no modulo arithmetic).
//  - count: +1 on enq only, -1 on deq only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
//  - out$first = storage[rd_ptr] combinationally; no enq->first bypass: data enqueued into an
//    empty FIFO at edge N appears on out$first and out$first__RDY rises after edge N (1-cycle latency).
//  - Simultaneous enq+deq when empty: deq not ready, only enq fires.
//  - Simultaneous enq+deq when full: PIPELINED=0 -> only deq fires (count DEPTH-1);
//    PIPELINED=1 -> both fire, count stays DEPTH, slot vacated by deq is rewritten.
//  - PIPELINED=1 creates a combinational out$deq__ENA -> in$enq__RDY path; documented, intended.
//  - ENA asserted while RDY low: no state change, no error signalled.
// STRUCTURE
//  - fifo_pkg: function ptr_next(ptr, DEPTH); localparams PTR_W=max(1,$clog2(DEPTH)),
//    CNT_W=$clog2(DEPTH+1); shared by all future buffered method adapters.
//  - One sub-module fifo_n_storage (WIDTH x DEPTH register array, 1 write port, 1 async read
//    port, no reset); fifo_n_pipe holds pointers, count and RDY logic.
// TESTING
//  T1 reset: assert nRST=0 mid-stream with count=3 -> same cycle count=0, in$enq__RDY=1,
//     out$deq__RDY=0; after release enq 0xA -> out$first=0xA next cycle.
//  T2 fill/drain DEPTH=4: enq 1,2,3,4 -> count=4, in$enq__RDY=0; 5th enq ignored;
//     deq x4 -> out$first sequence 1,2,3,4, then out$deq__RDY=0.
//  T3 wrap DEPTH=3: 10 rounds enq/deq of incrementing values, interleaved partially
//     -> order preserved across pointer wrap, count matches scoreboard every cycle.
//  T4 simultaneous at full: PIPELINED=0 enq 0x55 + deq -> 0x55 dropped, count 4->3;
//     PIPELINED=1 same stimulus -> 0x55 accepted, count stays 4, appears after 3 deqs.
//  T5 simultaneous at empty: enq 0x7 + deq_ENA -> count=1, out$first=0x7 next cycle.
//  T6 random ENA on both sides 10k cycles, WIDTH=8, DEPTH=5 -> no loss/dup/reorder vs reference queue.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for buffered method adapters: pointer/count width derivation,
// pointer increment with wrap at an arbitrary depth, and the per-cycle
// operation encoding used to update occupancy.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Per-cycle transfer combination, encoded as {enq_fire, deq_fire}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Pointer width: enough bits to address DEPTH entries, never less than one.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy width: must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap compare so non-power-of-two depths work without modulo.
    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_n_storage.sv
// -----------------------------------------------------------------------------
// fifo_n_storage
// WIDTH x DEPTH register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   CLK      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address (PTR_W)
//   i_wdata  in   write data (WIDTH)
//   i_raddr  in   read address (PTR_W)
//   o_rdata  out  read data, combinational from i_raddr (WIDTH)
// -----------------------------------------------------------------------------
module fifo_n_storage #(
    parameter int unsigned WIDTH = 704,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             CLK,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; address is always < DEPTH because pointers wrap explicitly.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_n_pipe.sv
// -----------------------------------------------------------------------------
// fifo_n_pipe
// N-entry FIFO between an atomic-method producer (enq) and consumer
// (deq/first), with an occupancy count and an optional pipelined mode that
// accepts an enqueue while full when a dequeue fires in the same cycle.
// Ports:
//   CLK            in   clock
//   nRST           in   async active-low reset
//   in_enq_ena     in   enqueue strobe (ignored unless in_enq_rdy)
//   in_enq_v       in   enqueue data (WIDTH)
//   in_enq_rdy     out  enqueue permitted this cycle
//   out_deq_ena    in   dequeue strobe (ignored unless out_deq_rdy)
//   out_deq_rdy    out  dequeue permitted (not empty)
//   out_first      out  head entry (WIDTH), valid while out_first_rdy
//   out_first_rdy  out  head valid
//   count          out  occupancy 0..DEPTH
// With PIPELINED=1 there is an intended combinational path
// out_deq_ena -> in_enq_rdy.
// -----------------------------------------------------------------------------
module fifo_n_pipe
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 704,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PIPELINED = 0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_enq_ena,
    input  logic [WIDTH-1:0]           in_enq_v,
    output logic                       in_enq_rdy,
    input  logic                       out_deq_ena,
    output logic                       out_deq_rdy,
    output logic [WIDTH-1:0]           out_first,
    output logic                       out_first_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_not_full;
    logic             w_not_empty;
    logic             w_pipe_pass;
    logic             w_enq_fire;
    logic             w_deq_fire;
    fifo_op_e         w_op;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // Ready/fire decode; all status derives from the occupancy register.
    assign w_not_full  = (r_count != FULL_CNT);
    assign w_not_empty = (r_count != '0);
    // Full-but-draining slot reuse, only when pipelined mode is built in.
    assign w_pipe_pass = (PIPELINED != 0) && out_deq_ena && w_not_empty;

    assign in_enq_rdy    = w_not_full | w_pipe_pass;
    assign out_deq_rdy   = w_not_empty;
    assign out_first_rdy = w_not_empty;

    assign w_enq_fire = in_enq_ena & in_enq_rdy;
    assign w_deq_fire = out_deq_ena & w_not_empty;
    assign w_op       = fifo_op_e'({w_enq_fire, w_deq_fire});

    // Next pointers and occupancy.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        if (w_enq_fire) begin
            w_wr_ptr_nxt = PTR_W'(ptr_next(32'(r_wr_ptr), DEPTH));
        end
        if (w_deq_fire) begin
            w_rd_ptr_nxt = PTR_W'(ptr_next(32'(r_rd_ptr), DEPTH));
        end
        case (w_op)
            OP_ENQ:  w_count_nxt = r_count + CNT_W'(1);
            OP_DEQ:  w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers; storage contents survive reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign count = r_count;

    // Head is read straight from storage: no enq->first bypass.
    fifo_n_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .CLK     (CLK),
        .i_we    (w_enq_fire),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_enq_v),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_first)
    );

    // Occupancy stays within 0..DEPTH.
    a_count_bound: assert property (@(posedge CLK) disable iff (!nRST)
        r_count <= FULL_CNT);

    // A lone enqueue never lands on a full buffer.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
        !(w_enq_fire && !w_deq_fire && !w_not_full));

endmodule

// File: tb/tb_fifo_n_pipe.sv
// -----------------------------------------------------------------------------
// tb_fifo_n_pipe
// Four instances: [0] DEPTH=4, [1] DEPTH=4 pipelined, [2] DEPTH=3, [3] DEPTH=5,
// all WIDTH=8. A per-instance reference queue (array with shift-on-dequeue)
// predicts readiness, occupancy and head data.
// -----------------------------------------------------------------------------
module tb_fifo_n_pipe;

    localparam int unsigned NI = 4;

    logic       clk;
    logic       nrst;
    logic       e_ena [NI];
    logic [7:0] e_v   [NI];
    logic       d_ena [NI];
    logic       e_rdy [NI];
    logic       d_rdy [NI];
    logic       f_rdy [NI];
    logic [7:0] first [NI];
    logic [3:0] cnt   [NI];

    int         m_size [NI];
    logic [7:0] m_data [NI][8];
    int         m_dep  [NI];
    bit         m_pipe [NI];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned DP = (g == 2) ? 3 : ((g == 3) ? 5 : 4);
        localparam int unsigned PP = (g == 1) ? 1 : 0;
        localparam int unsigned CW = $clog2(DP + 1);
        logic [CW-1:0] w_cnt;

        fifo_n_pipe #(
            .WIDTH     (8),
            .DEPTH     (DP),
            .PIPELINED (PP)
        ) u_dut (
            .CLK           (clk),
            .nRST          (nrst),
            .in_enq_ena    (e_ena[g]),
            .in_enq_v      (e_v[g]),
            .in_enq_rdy    (e_rdy[g]),
            .out_deq_ena   (d_ena[g]),
            .out_deq_rdy   (d_rdy[g]),
            .out_first     (first[g]),
            .out_first_rdy (f_rdy[g]),
            .count         (w_cnt)
        );

        assign cnt[g] = 4'(w_cnt);
    end

    task automatic model_reset();
        for (int k = 0; k < NI; k++) m_size[k] = 0;
    endtask

    // One clock of stimulus on instance k; returns the DUT's enq ready seen
    // before the edge and the ready the reference predicts.
    task automatic apply(input int k, input bit e, input logic [7:0] v, input bit d,
                         output logic seen_rdy, output bit exp_rdy);
        bit efire;
        bit dfire;
        e_ena[k] = e;
        e_v[k]   = v;
        d_ena[k] = d;
        #1;
        seen_rdy = e_rdy[k];
        exp_rdy  = (m_size[k] < m_dep[k]) || (m_pipe[k] && d && (m_size[k] > 0));
        efire    = e && exp_rdy;
        dfire    = d && (m_size[k] > 0);
        @(posedge clk);
        #1;
        if (dfire) begin
            for (int i = 0; i < 7; i++) m_data[k][i] = m_data[k][i+1];
            m_size[k]--;
        end
        if (efire) begin
            m_data[k][m_size[k]] = v;
            m_size[k]++;
        end
        e_ena[k] = 1'b0;
        d_ena[k] = 1'b0;
    endtask

    task automatic test_reset();
        logic s;
        bit   x;
        nrst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (cnt[k] !== 4'd0) begin
                n_err++; $display("FAIL reset_count k=%0d got=%0d exp=0", k, cnt[k]);
            end
            n_checks++;
            if (e_rdy[k] !== 1'b1) begin
                n_err++; $display("FAIL reset_enq_rdy k=%0d got=%b exp=1", k, e_rdy[k]);
            end
            n_checks++;
            if (d_rdy[k] !== 1'b0 || f_rdy[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_deq_rdy k=%0d got=%b/%b exp=0/0", k, d_rdy[k], f_rdy[k]);
            end
        end
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) apply(0, 1'b1, 8'(8'h21 + i), 1'b0, s, x);
        n_checks++;
        if (cnt[0] !== 4'd3) begin
            n_err++; $display("FAIL pre_reset_count got=%0d exp=3", cnt[0]);
        end
        // Mid-cycle reset with three entries held.
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (cnt[0] !== 4'd0 || e_rdy[0] !== 1'b1 || d_rdy[0] !== 1'b0 || f_rdy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midreset cnt/enq/deq/first got=%0d/%b/%b/%b exp=0/1/0/0",
                     cnt[0], e_rdy[0], d_rdy[0], f_rdy[0]);
        end
        model_reset();
        #2;
        nrst = 1'b1;
        apply(0, 1'b1, 8'h0A, 1'b0, s, x);
        n_checks++;
        if (f_rdy[0] !== 1'b1 || first[0] !== 8'h0A || cnt[0] !== 4'd1) begin
            n_err++;
            $display("FAIL reset_then_enq rdy/first/cnt got=%b/%h/%0d exp=1/0a/1",
                     f_rdy[0], first[0], cnt[0]);
        end
        apply(0, 1'b0, 8'h00, 1'b1, s, x);
    endtask

    task automatic test_fill_drain();
        logic s;
        bit   x;
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1'b1, 8'(i), 1'b0, s, x);
            n_checks++;
            if (cnt[0] !== 4'(i)) begin
                n_err++; $display("FAIL fill_count got=%0d exp=%0d", cnt[0], i);
            end
        end
        n_checks++;
        if (e_rdy[0] !== 1'b0) begin
            n_err++; $display("FAIL full_enq_rdy got=%b exp=0", e_rdy[0]);
        end
        apply(0, 1'b1, 8'd5, 1'b0, s, x);
        n_checks++;
        if (s !== 1'b0 || cnt[0] !== 4'd4) begin
            n_err++; $display("FAIL fifth_enq rdy/cnt got=%b/%0d exp=0/4", s, cnt[0]);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (f_rdy[0] !== 1'b1 || first[0] !== 8'(i)) begin
                n_err++; $display("FAIL drain_first rdy/data got=%b/%h exp=1/%h", f_rdy[0], first[0], 8'(i));
            end
            apply(0, 1'b0, 8'h00, 1'b1, s, x);
        end
        n_checks++;
        if (d_rdy[0] !== 1'b0 || cnt[0] !== 4'd0) begin
            n_err++; $display("FAIL drained rdy/cnt got=%b/%0d exp=0/0", d_rdy[0], cnt[0]);
        end
    endtask

    task automatic test_wrap();
        logic       s;
        bit         x;
        bit         e;
        bit         d;
        logic [7:0] val;
        val = 8'h30;
        for (int cyc = 0; cyc < 80; cyc++) begin
            e = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 2) != 0);
            apply(2, e, val, d, s, x);
            if (e && x) val++;
            n_checks++;
            if (s !== x) begin
                n_err++; $display("FAIL wrap_enq_rdy cyc=%0d got=%b exp=%b", cyc, s, x);
            end
            n_checks++;
            if (cnt[2] !== 4'(m_size[2])) begin
                n_err++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, cnt[2], m_size[2]);
            end
            if (m_size[2] > 0) begin
                n_checks++;
                if (first[2] !== m_data[2][0]) begin
                    n_err++; $display("FAIL wrap_first cyc=%0d got=%h exp=%h", cyc, first[2], m_data[2][0]);
                end
            end
        end
        for (int i = 0; i < 3; i++) apply(2, 1'b0, 8'h00, 1'b1, s, x);
        n_checks++;
        if (cnt[2] !== 4'd0) begin
            n_err++; $display("FAIL wrap_drain got=%0d exp=0", cnt[2]);
        end
    endtask

    task automatic test_full_simul();
        logic s;
        bit   x;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) apply(k, 1'b1, 8'(8'h11 + i), 1'b0, s, x);
            apply(k, 1'b1, 8'h55, 1'b1, s, x);
            n_checks++;
            if (s !== 1'(k == 1)) begin
                n_err++; $display("FAIL full_simul_rdy k=%0d got=%b exp=%b", k, s, k == 1);
            end
            n_checks++;
            if (cnt[k] !== ((k == 1) ? 4'd4 : 4'd3)) begin
                n_err++; $display("FAIL full_simul_count k=%0d got=%0d exp=%0d", k, cnt[k], (k == 1) ? 4 : 3);
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (first[k] !== 8'(8'h12 + i)) begin
                    n_err++; $display("FAIL full_simul_order k=%0d got=%h exp=%h", k, first[k], 8'(8'h12 + i));
                end
                apply(k, 1'b0, 8'h00, 1'b1, s, x);
            end
            n_checks++;
            if (k == 1) begin
                if (f_rdy[k] !== 1'b1 || first[k] !== 8'h55) begin
                    n_err++; $display("FAIL pipe_accept rdy/data got=%b/%h exp=1/55", f_rdy[k], first[k]);
                end
                apply(k, 1'b0, 8'h00, 1'b1, s, x);
            end else begin
                if (d_rdy[k] !== 1'b0) begin
                    n_err++; $display("FAIL nopipe_drop rdy got=%b exp=0", d_rdy[k]);
                end
            end
        end
    endtask

    task automatic test_empty_simul();
        logic s;
        bit   x;
        for (int k = 0; k < 2; k++) begin
            e_ena[k] = 1'b1;
            e_v[k]   = 8'h07;
            d_ena[k] = 1'b1;
            #1;
            n_checks++;
            if (d_rdy[k] !== 1'b0 || f_rdy[k] !== 1'b0 || e_rdy[k] !== 1'b1) begin
                n_err++;
                $display("FAIL empty_simul_pre k=%0d deq/first/enq got=%b/%b/%b exp=0/0/1",
                         k, d_rdy[k], f_rdy[k], e_rdy[k]);
            end
            apply(k, 1'b1, 8'h07, 1'b1, s, x);
            n_checks++;
            if (cnt[k] !== 4'd1 || first[k] !== 8'h07 || f_rdy[k] !== 1'b1) begin
                n_err++;
                $display("FAIL empty_simul k=%0d cnt/first/rdy got=%0d/%h/%b exp=1/07/1",
                         k, cnt[k], first[k], f_rdy[k]);
            end
            apply(k, 1'b0, 8'h00, 1'b1, s, x);
        end
    endtask

    task automatic test_random(input int k, input int cycles);
        logic s;
        bit   x;
        bit   e;
        bit   d;
        int   errs_before;
        errs_before = n_err;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            e = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 50);
            apply(k, e, 8'($urandom), d, s, x);
            n_checks++;
            if (s !== x) begin
                n_err++; $display("FAIL rand_enq_rdy k=%0d cyc=%0d got=%b exp=%b", k, cyc, s, x);
            end
            n_checks++;
            if (cnt[k] !== 4'(m_size[k]) || d_rdy[k] !== 1'(m_size[k] > 0)) begin
                n_err++;
                $display("FAIL rand_count k=%0d cyc=%0d got=%0d/%b exp=%0d", k, cyc, cnt[k], d_rdy[k], m_size[k]);
            end
            if (m_size[k] > 0) begin
                n_checks++;
                if (first[k] !== m_data[k][0]) begin
                    n_err++; $display("FAIL rand_first k=%0d cyc=%0d got=%h exp=%h", k, cyc, first[k], m_data[k][0]);
                end
            end
            if (n_err - errs_before > 20) break;
        end
        for (int i = 0; i < 6; i++) apply(k, 1'b0, 8'h00, 1'b1, s, x);
    endtask

    initial begin
        nrst   = 1'b1;
        m_dep  = '{4, 4, 3, 5};
        m_pipe = '{0, 1, 0, 0};
        for (int k = 0; k < NI; k++) begin
            e_ena[k] = 1'b0;
            e_v[k]   = 8'h00;
            d_ena[k] = 1'b0;
        end
        model_reset();
        #2;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_simul();
        test_empty_simul();
        test_random(3, 10000);
        test_random(1, 2000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
